irq_prio_ctrl: RTL

- Parametrised interrupt capture and priority controller; generalises the fixed DIO1 (IRQ16) / timer (IRQ17) pair to NUM_IRQ channels.
- Each channel has per-channel edge/level mode, enable, write-1-to-clear pending, and fixed lowest-index-wins arbitration.
- Sits between the peripheral interrupt lines and the core's interrupt input.
- Presents one registered request with a stable mcause value, held through a req/ack handshake.

---
 rtl/irq_prio_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/irq_prio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_ctrl
// Purpose  : Interrupt capture and fixed-priority controller. Synchronises
//            NUM_IRQ raw interrupt lines, captures rising edges (or passes
//            levels) per channel, masks with per-channel enables and presents
//            one registered request with a stable mcause value to the core,
//            held through a req/ack handshake. Lowest channel index wins.
// Ports    : clk            - system clock
//            rst            - asynchronous active-high reset
//            irq_in         - raw asynchronous interrupt lines
//            irq_mode_edge  - per channel: 1 = rising edge, 0 = level
//            irq_en         - per-channel enable
//            clr_mask       - write-1-to-clear for edge pending bits (pulse)
//            irq_ack        - core accepts the current request
//            irq_req        - registered interrupt request
//            irq_cause      - mcause of the current request
//            irq_id         - channel index of the current request
//            irq_pending    - raw pending vector, not masked by irq_en
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_ctrl #(
    parameter int NUM_IRQ     = 4,
    parameter int BASE_CAUSE  = 16,
    parameter int CAUSE_W     = 5,
    parameter int SYNC_STAGES = 2,
    parameter int AUTO_CLR    = 1,
    localparam int c_id_w     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mode_edge,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [NUM_IRQ-1:0] clr_mask,
    input  logic               irq_ack,
    output logic               irq_req,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [c_id_w-1:0]  irq_id,
    output logic [NUM_IRQ-1:0] irq_pending
);

    localparam logic [CAUSE_W-1:0] c_base_cause = CAUSE_W'(BASE_CAUSE);

    // Parameter sanity checks, resolved at elaboration.
    generate
        if (BASE_CAUSE + NUM_IRQ - 1 >= (1 << CAUSE_W)) begin : g_cause_chk
            $error("irq_prio_ctrl: BASE_CAUSE+NUM_IRQ-1 does not fit in CAUSE_W bits");
        end
        if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_num_chk
            $error("irq_prio_ctrl: NUM_IRQ must be 1..16");
        end
        if (SYNC_STAGES < 1) begin : g_sync_chk
            $error("irq_prio_ctrl: SYNC_STAGES must be >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_IRQ-1:0]  r_sync [SYNC_STAGES];
    logic [NUM_IRQ-1:0]  r_hist;
    logic [NUM_IRQ-1:0]  r_pend_e;
    logic [c_id_w-1:0]   r_id;
    logic [CAUSE_W-1:0]  r_cause;

    logic [NUM_IRQ-1:0]  w_sync;
    logic [NUM_IRQ-1:0]  w_rise;
    logic [NUM_IRQ-1:0]  w_ack_clr;
    logic [NUM_IRQ-1:0]  w_pend_e_nxt;
    logic [NUM_IRQ-1:0]  w_pending;
    logic [NUM_IRQ-1:0]  w_active;
    logic [c_id_w-1:0]   w_win;
    logic [c_id_w-1:0]   w_id_nxt;
    logic [CAUSE_W-1:0]  w_cause_nxt;

    assign w_sync = r_sync[SYNC_STAGES-1];
    // History flop resets to 0, so a line held high through reset release
    // produces exactly one rising edge.
    assign w_rise = w_sync & ~r_hist;

    // Ack only clears the acknowledged channel, and only in REQ.
    assign w_ack_clr = ((r_state == ST_REQ) && irq_ack && (AUTO_CLR != 0))
                       ? (NUM_IRQ'(1) << r_id) : '0;

    // Set has priority over clear so an edge arriving with a clear is kept.
    // Level channels carry no edge state.
    assign w_pend_e_nxt = ((r_pend_e & ~clr_mask & ~w_ack_clr) | w_rise) & irq_mode_edge;

    assign w_pending = (irq_mode_edge & r_pend_e) | (~irq_mode_edge & w_sync);
    assign w_active  = w_pending & irq_en;

    // Fixed priority: scan downwards so the lowest set index is left last.
    always_comb begin
        w_win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_win = c_id_w'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_IDLE: begin
                if (|w_active) begin
                    w_state_nxt = ST_REQ;
                    w_id_nxt    = w_win;
                    w_cause_nxt = c_base_cause + CAUSE_W'(w_win);
                end
            end
            ST_REQ: begin
                // No preemption: id/cause stay frozen until ack or withdraw.
                if (irq_ack || !w_active[r_id]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_hist   <= '0;
            r_pend_e <= '0;
            r_state  <= ST_IDLE;
            r_id     <= '0;
            r_cause  <= '0;
        end else begin
            r_sync[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_hist   <= w_sync;
            r_pend_e <= w_pend_e_nxt;
            r_state  <= w_state_nxt;
            r_id     <= w_id_nxt;
            r_cause  <= w_cause_nxt;
        end
    end

    assign irq_req     = (r_state == ST_REQ);
    assign irq_cause   = r_cause;
    assign irq_id      = r_id;
    assign irq_pending = w_pending;

endmodule
`default_nettype wire
